// File: rtl/iir8_inv.sv
// 8th-order all-pole IIR (inverse of an 8-tap FIR): y[n] = b0*x[n] - sum(ak*y[n-k]).
// One time-shared multiplier; 10 edges from accepted ce to output, one sample per 11 cycles.
module iir8_inv #(
  parameter int pw_io_width      = 12,
  parameter int pw_io_decimal    = 11,
  parameter int pw_coeff_decimal = 29
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ce,
  input  logic                          i_clr,
  input  logic signed [31:0]            isp_coeff_0,
  input  logic signed [31:0]            isp_coeff_1,
  input  logic signed [31:0]            isp_coeff_2,
  input  logic signed [31:0]            isp_coeff_3,
  input  logic signed [31:0]            isp_coeff_4,
  input  logic signed [31:0]            isp_coeff_5,
  input  logic signed [31:0]            isp_coeff_6,
  input  logic signed [31:0]            isp_coeff_7,
  input  logic signed [31:0]            isp_coeff_8,
  input  logic signed [pw_io_width-1:0] isp_in,
  output logic signed [pw_io_width-1:0] osp_out,
  output logic                          o_valid,
  output logic                          o_busy,
  output logic                          o_sat,
  output logic                          o_overrun
);

  localparam int lp_prod_w   = pw_io_width + 32;
  // Products carry input + coefficient fraction bits; drop down to the output fraction.
  localparam int lp_in_frac  = pw_io_decimal;
  localparam int lp_out_frac = pw_io_decimal;
  localparam int lp_shift    = pw_coeff_decimal + lp_in_frac - lp_out_frac;
  localparam logic signed [63:0] lp_max = (64'sd1 <<< (pw_io_width - 1)) - 64'sd1;
  localparam logic signed [63:0] lp_min = -(64'sd1 <<< (pw_io_width - 1));

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic [3:0]                    r_k;
  logic signed [31:0]            r_coeff [0:8];
  logic signed [pw_io_width-1:0] r_x;
  logic signed [pw_io_width-1:0] r_y [1:8];
  logic signed [63:0]            r_acc;

  logic signed [31:0]            w_coeff_in [0:8];
  logic signed [pw_io_width-1:0] w_mul_a;
  logic signed [31:0]            w_mul_b;
  logic signed [lp_prod_w-1:0]   w_prod;
  logic signed [63:0]            w_prod_ext;
  logic signed [63:0]            w_r;
  logic                          w_sat_hi;
  logic                          w_sat_lo;
  logic signed [pw_io_width-1:0] w_result;

  assign w_coeff_in[0] = isp_coeff_0;
  assign w_coeff_in[1] = isp_coeff_1;
  assign w_coeff_in[2] = isp_coeff_2;
  assign w_coeff_in[3] = isp_coeff_3;
  assign w_coeff_in[4] = isp_coeff_4;
  assign w_coeff_in[5] = isp_coeff_5;
  assign w_coeff_in[6] = isp_coeff_6;
  assign w_coeff_in[7] = isp_coeff_7;
  assign w_coeff_in[8] = isp_coeff_8;

  // Tap 0 multiplies the new sample by b0; tap k multiplies y[n-k] by ak.
  always_comb begin
    w_mul_a = r_x;
    w_mul_b = r_coeff[0];
    for (int i = 1; i <= 8; i++) begin
      if (r_k == 4'(i)) begin
        w_mul_a = r_y[i];
        w_mul_b = r_coeff[i];
      end
    end
  end

  assign w_prod     = lp_prod_w'(w_mul_a) * lp_prod_w'(w_mul_b);
  assign w_prod_ext = 64'(w_prod);

  assign w_r      = r_acc >>> lp_shift;
  assign w_sat_hi = (w_r > lp_max);
  assign w_sat_lo = (w_r < lp_min);
  assign w_result = w_sat_hi ? lp_max[pw_io_width-1:0] :
                    w_sat_lo ? lp_min[pw_io_width-1:0] :
                               w_r[pw_io_width-1:0];

  assign o_busy = (r_state != IDLE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (ce) w_state_next = MAC;
      MAC:     if (r_k == 4'd8) w_state_next = WRITE;
      WRITE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (i_clr) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      osp_out   <= '0;
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
      o_overrun <= 1'b0;
      r_k       <= '0;
      r_x       <= '0;
      r_acc     <= '0;
      for (int i = 0; i <= 8; i++) r_coeff[i] <= '0;
      for (int i = 1; i <= 8; i++) r_y[i] <= '0;
    end else begin
      o_valid   <= 1'b0;
      o_sat     <= 1'b0;
      o_overrun <= 1'b0;
      if (i_clr) begin
        // Abort: history and accumulator cleared, osp_out intentionally kept.
        r_acc <= '0;
        r_k   <= '0;
        for (int i = 1; i <= 8; i++) r_y[i] <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (ce) begin
              r_x   <= isp_in;
              r_acc <= '0;
              r_k   <= '0;
              for (int i = 0; i <= 8; i++) r_coeff[i] <= w_coeff_in[i];
            end
          end
          MAC: begin
            if (ce) o_overrun <= 1'b1;
            if (r_k == 4'd0) r_acc <= r_acc + w_prod_ext;
            else             r_acc <= r_acc - w_prod_ext;
            r_k <= r_k + 4'd1;
          end
          WRITE: begin
            if (ce) o_overrun <= 1'b1;
            osp_out <= w_result;
            o_valid <= 1'b1;
            o_sat   <= w_sat_hi | w_sat_lo;
            r_y[1]  <= w_result;
            for (int i = 2; i <= 8; i++) r_y[i] <= r_y[i-1];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iir8_inv.sv
// Directed bench for iir8_inv: reset, impulse response, timing, overrun, clear, saturation.
module tb_iir8_inv;
  logic        clk;
  logic        rstn;
  logic        ce;
  logic        i_clr;
  logic [31:0] c0, c1, c2, c3, c4, c5, c6, c7, c8;
  logic [11:0] isp_in;
  logic [11:0] osp_out;
  logic        o_valid, o_busy, o_sat, o_overrun;
  int          checks;
  int          errors;

  iir8_inv dut (
    .clk(clk), .rstn(rstn), .ce(ce), .i_clr(i_clr),
    .isp_coeff_0(c0), .isp_coeff_1(c1), .isp_coeff_2(c2), .isp_coeff_3(c3),
    .isp_coeff_4(c4), .isp_coeff_5(c5), .isp_coeff_6(c6), .isp_coeff_7(c7),
    .isp_coeff_8(c8), .isp_in(isp_in), .osp_out(osp_out),
    .o_valid(o_valid), .o_busy(o_busy), .o_sat(o_sat), .o_overrun(o_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full sample: ce for one edge, then wait (bounded) for o_valid.
  task automatic run(input string tag, input logic [11:0] x, input logic [11:0] exp,
                     input logic exp_sat);
    int n;
    bit busy_ok;
    isp_in = x;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    isp_in = ~x;
    chk({tag, "_busy_e0"}, o_busy, 1);
    chk({tag, "_valid_e0"}, o_valid, 0);
    n = 0;
    busy_ok = 1'b1;
    while (o_valid !== 1'b1 && n < 20) begin
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      tick();
      n++;
    end
    $display("sample %s x=%h out=%h sat=%b latency=%0d", tag, x, osp_out, o_sat, n);
    chk({tag, "_latency"}, n, 10);
    chk({tag, "_out"}, osp_out, exp);
    chk({tag, "_sat"}, o_sat, exp_sat);
    chk({tag, "_busy_mac"}, busy_ok, 1);
    chk({tag, "_busy_done"}, o_busy, 0);
  endtask

  initial begin
    int nvalid;
    checks = 0;
    errors = 0;
    rstn = 1'b0; ce = 1'b0; i_clr = 1'b0; isp_in = '0;
    c0 = 32'h2000_0000; c1 = 32'h1000_0000;
    c2 = '0; c3 = '0; c4 = '0; c5 = '0; c6 = '0; c7 = '0; c8 = '0;

    // Reset state
    #1;
    chk("rst_out", osp_out, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_overrun", o_overrun, 0);
    #11 rstn = 1'b1;
    tick();
    chk("post_rst_valid", o_valid, 0);

    // Impulse response, back-to-back (each new ce lands on E11)
    run("imp0", 12'h400, 12'h400, 1'b0);
    run("imp1", 12'h000, 12'hE00, 1'b0);
    run("imp2", 12'h000, 12'h100, 1'b0);
    run("imp3", 12'h000, 12'hF80, 1'b0);
    run("imp4", 12'h000, 12'h040, 1'b0);
    tick();
    chk("imp4_valid_fall", o_valid, 0);

    // Overrun at E5, with coefficient and input changes mid-computation
    isp_in = 12'h000; ce = 1'b1; tick(); ce = 1'b0;
    c1 = '0; isp_in = 12'h7FF;
    repeat (4) tick();
    ce = 1'b1; tick(); ce = 1'b0;
    chk("ovr_pulse", o_overrun, 1);
    tick();
    chk("ovr_fall", o_overrun, 0);
    repeat (3) tick();
    chk("ovr_valid_e9", o_valid, 0);
    tick();
    $display("overrun sample out=%h valid=%b", osp_out, o_valid);
    chk("ovr_valid", o_valid, 1);
    chk("ovr_out", osp_out, 12'hFE0);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid === 1'b1) nvalid++;
    end
    chk("ovr_no_second_valid", nvalid, 0);
    c1 = 32'h1000_0000;

    // Clear at E4 of a computation
    isp_in = 12'h000; ce = 1'b1; tick(); ce = 1'b0;
    repeat (3) tick();
    i_clr = 1'b1; tick(); i_clr = 1'b0;
    chk("clr_busy", o_busy, 0);
    chk("clr_out_hold", osp_out, 12'hFE0);
    nvalid = 0;
    for (int i = 0; i < 12; i++) begin
      if (o_valid === 1'b1) nvalid++;
      tick();
    end
    $display("clear abort valid_count=%0d out=%h", nvalid, osp_out);
    chk("clr_no_valid", nvalid, 0);
    run("clr0", 12'h400, 12'h400, 1'b0);
    run("clr1", 12'h000, 12'hE00, 1'b0);

    // Saturation both ways
    c0 = 32'h7FFF_FFFF; c1 = '0;
    run("satp", 12'h7FF, 12'h7FF, 1'b1);
    run("satn", 12'h800, 12'h800, 1'b1);
    tick();
    chk("sat_fall", o_sat, 0);

    // Asynchronous reset mid-MAC, then fresh response with zero history
    c0 = 32'h2000_0000; c1 = 32'h1000_0000;
    isp_in = 12'h400; ce = 1'b1; tick(); ce = 1'b0;
    repeat (3) tick();
    #2 rstn = 1'b0;
    #1;
    $display("async reset out=%h busy=%b valid=%b", osp_out, o_busy, o_valid);
    chk("arst_out", osp_out, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_valid", o_valid, 0);
    chk("arst_sat", o_sat, 0);
    chk("arst_overrun", o_overrun, 0);
    #1 rstn = 1'b1;
    tick();
    chk("arst_no_valid", o_valid, 0);
    run("arst0", 12'h400, 12'h400, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
